// File: rtl/alarm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : alarm_pkg                                                 |
// | Purpose  : Shared types and constants for the alarm setpoint editor: |
// |            editor FSM state encoding and default field moduli.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package alarm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EDIT = 1'b1
    } state_t;

    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HOUR_MOD = 24;

endpackage
`default_nettype wire

// File: rtl/key_edge_repeat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : key_edge_repeat                                           |
// | Purpose  : Rising-edge detector for one debounced key, with an       |
// |            optional hold-to-repeat counter (AUTO_REPEAT_EN build      |
// |            macro, and REPEAT_EN per instance).                       |
// | Ports    : clk, reset   - clock, synchronous active-high reset       |
// |            key          - debounced key level                        |
// |            repeat_ok    - repeating allowed this cycle; low clears   |
// |                           the repeat counter                         |
// |            step         - single-cycle step pulse (edge or repeat)   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module key_edge_repeat #(
    parameter bit REPEAT_EN     = 1'b0,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    input  logic repeat_ok,
    output logic step
);

    logic key_prev;
    logic edge_det;

    // The previous-level register tracks the key during reset as well, so a
    // key held through reset release produces no edge.
    always_ff @(posedge clk) begin
        key_prev <= key;
    end

    assign edge_det = key & ~key_prev;

`ifdef AUTO_REPEAT_EN
    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int CNT_W   = $clog2(MAX_CNT + 1);

            logic [CNT_W-1:0] cnt;       // cycles elapsed since the last step
            logic             armed;     // first repeat already issued
            logic             active;    // hold started with a valid edge
            logic [CNT_W-1:0] thresh;
            logic             fire;

            assign thresh = armed ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY);
            assign fire   = active & key & key_prev & repeat_ok & (cnt == thresh);

            always_ff @(posedge clk) begin
                if (reset || !key || !repeat_ok) begin
                    cnt    <= '0;
                    armed  <= 1'b0;
                    active <= 1'b0;
                end else if (edge_det) begin
                    cnt    <= CNT_W'(1);
                    armed  <= 1'b0;
                    active <= 1'b1;
                end else if (active) begin
                    if (cnt == thresh) begin
                        cnt   <= CNT_W'(1);
                        armed <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end

            assign step = edge_det | fire;
        end else begin : g_no_repeat
            logic unused_cfg;
            assign unused_cfg = ^{repeat_ok, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
            assign step       = edge_det;
        end
    endgenerate
`else
    logic unused_cfg;
    assign unused_cfg = ^{repeat_ok, REPEAT_EN, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
    assign step       = edge_det;
`endif

endmodule
`default_nettype wire

// File: rtl/time_field_editor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : time_field_editor                                         |
// | Purpose  : Key-driven editor for NUM_FIELDS modular time fields with |
// |            edit mode, cursor, increment/decrement with wrap, and     |
// |            optional hold-to-repeat (build macro AUTO_REPEAT_EN).     |
// | Ports    : clk, reset         - clock, synchronous active-high reset |
// |            set/left/right/up/down_key - debounced key levels         |
// |            fields             - field values, field 0 in LSBs        |
// |            cursor             - selected field index                 |
// |            editing            - high while in EDIT                   |
// |            inc_pulse/dec_pulse- one-hot per-field step pulses        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module time_field_editor
    import alarm_pkg::*;
#(
    parameter int                           NUM_FIELDS    = 3,
    parameter int                           FIELD_W       = 6,
    // A modulus slice of zero stands for 2**FIELD_W, which does not fit.
    parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MODS   = {6'(HOUR_MOD), 6'(MIN_MOD), 6'(SEC_MOD)},
    parameter int                           REPEAT_DELAY  = 50_000_000,
    parameter int                           REPEAT_PERIOD = 10_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          set_key,
    input  logic                          left_key,
    input  logic                          right_key,
    input  logic                          up_key,
    input  logic                          down_key,
    output logic [NUM_FIELDS*FIELD_W-1:0] fields,
    output logic [$clog2(NUM_FIELDS)-1:0] cursor,
    output logic                          editing,
    output logic [NUM_FIELDS-1:0]         inc_pulse,
    output logic [NUM_FIELDS-1:0]         dec_pulse
);

    localparam int               CW   = $clog2(NUM_FIELDS);
    localparam logic [CW-1:0]    LAST = CW'(NUM_FIELDS - 1);
    localparam logic [FIELD_W:0] ONE  = (FIELD_W+1)'(1);
    localparam logic [FIELD_W:0] FULL = (FIELD_W+1)'(2**FIELD_W);

    state_t             state;
    logic [FIELD_W-1:0] val     [NUM_FIELDS];
    logic [FIELD_W:0]   mod_ext [NUM_FIELDS];
    logic [FIELD_W-1:0] inc_val [NUM_FIELDS];
    logic [FIELD_W-1:0] dec_val [NUM_FIELDS];

    logic set_step, left_step, right_step, up_step, down_step;
    logic updown_ok;

    // Repeating stops on a set edge, outside EDIT, or with both keys down.
    assign updown_ok = (state == EDIT) & ~set_step & ~(up_key & down_key);

    key_edge_repeat #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_set   (.clk(clk), .reset(reset), .key(set_key),   .repeat_ok(1'b0),      .step(set_step));
    key_edge_repeat #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_left  (.clk(clk), .reset(reset), .key(left_key),  .repeat_ok(1'b0),      .step(left_step));
    key_edge_repeat #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_right (.clk(clk), .reset(reset), .key(right_key), .repeat_ok(1'b0),      .step(right_step));
    key_edge_repeat #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_up    (.clk(clk), .reset(reset), .key(up_key),    .repeat_ok(updown_ok), .step(up_step));
    key_edge_repeat #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_down  (.clk(clk), .reset(reset), .key(down_key),  .repeat_ok(updown_ok), .step(down_step));

    generate
        for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
            logic [FIELD_W-1:0] raw;
            assign raw          = FIELD_MODS[gi*FIELD_W +: FIELD_W];
            assign mod_ext[gi]  = (raw == '0) ? FULL : {1'b0, raw};
            assign fields[gi*FIELD_W +: FIELD_W] = val[gi];
        end
    endgenerate

    // Wrap arithmetic is done one bit wider so MOD = 2**FIELD_W compares cleanly.
    always_comb begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
            inc_val[i] = (({1'b0, val[i]} + ONE) == mod_ext[i]) ? '0 : FIELD_W'({1'b0, val[i]} + ONE);
            dec_val[i] = (val[i] == '0) ? FIELD_W'(mod_ext[i] - ONE) : FIELD_W'({1'b0, val[i]} - ONE);
        end
    end

    assign editing = (state == EDIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cursor    <= '0;
            inc_pulse <= '0;
            dec_pulse <= '0;
            for (int i = 0; i < NUM_FIELDS; i++) val[i] <= '0;
        end else begin
            inc_pulse <= '0;
            dec_pulse <= '0;
            if (set_step) begin
                if (state == IDLE) begin
                    state  <= EDIT;
                    cursor <= '0;
                end else begin
                    state <= IDLE;
                end
            end else if (state == EDIT) begin
                if (left_step && !right_step && cursor != LAST)
                    cursor <= cursor + CW'(1);
                else if (right_step && !left_step && cursor != '0)
                    cursor <= cursor - CW'(1);
                // The value step applies to the field selected before the move.
                for (int i = 0; i < NUM_FIELDS; i++) begin
                    if (cursor == CW'(i)) begin
                        if (up_step && !down_step) begin
                            val[i]       <= inc_val[i];
                            inc_pulse[i] <= 1'b1;
                        end else if (down_step && !up_step) begin
                            val[i]       <= dec_val[i];
                            dec_pulse[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/time_field_editor.md
# time_field_editor

Parametrised key-driven editor for NUM_FIELDS modular time fields (e.g. seconds/minutes/hours of an alarm setpoint). It replaces the fixed three-field alarm selector. It is fully synchronous: key edges are detected on clk, never used as clocks. It adds an edit mode, decrement, per-field wrap moduli and optional auto-repeat. It sits between the debounced push-button inputs and the alarm compare/display logic.

## Interface
- NUM_FIELDS, 3: number of editable fields; 2..8.
- FIELD_W, 6: bit width of each field value.
- FIELD_MODS, {6'd24,6'd60,6'd60}: packed NUM_FIELDS×FIELD_W moduli, field 0 in LSBs; each modulus is 2..2^FIELD_W.
- REPEAT_DELAY, 50_000_000: hold cycles before the first auto-repeat (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 10_000_000: cycles between repeats (AUTO_REPEAT_EN only).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- set_key  in  1  debounced level; a rising edge toggles edit mode.
- left_key  in  1  debounced level; a rising edge moves the cursor to the next higher field.
- right_key  in  1  debounced level; a rising edge moves the cursor to the next lower field.
- up_key  in  1  debounced level; a rising edge increments the selected field.
- down_key  in  1  debounced level; a rising edge decrements the selected field.
- fields  out  NUM_FIELDS*FIELD_W  current field values, field 0 in LSBs.
- cursor  out  $clog2(NUM_FIELDS)  index of the selected field.
- editing  out  1  high while in EDIT.
- inc_pulse  out  NUM_FIELDS  one-hot, one-cycle pulse per increment of a field.
- dec_pulse  out  NUM_FIELDS  one-hot, one-cycle pulse per decrement of a field.

## Operation
- Each key has an edge detector. While reset is high, the previous-level registers load the current key levels, so a key held through reset produces no edge.
- FSM states: IDLE, EDIT.
  - In IDLE, a set edge goes to EDIT and clears cursor to 0.
  - In EDIT, a set edge goes to IDLE; cursor and fields hold their values.
- In IDLE, left/right/up/down are ignored.
- Cursor moves only in EDIT:
  - Left: cursor+1, saturating at NUM_FIELDS-1.
  - Right: cursor-1, saturating at 0.
  - Left and right on the same cycle: no move.
- Value changes only in EDIT, and only on the field selected before any same-cycle cursor move:
  - Up: v = (v == MOD-1) ? 0 : v+1.
  - Down: v = (v == 0) ? MOD-1 : v-1.
  - Up and down on the same cycle: no change and no pulse.
- The set edge has priority. On a cycle with a set edge, all other edges are ignored.
- inc_pulse[i] / dec_pulse[i] assert for exactly the cycle in which field i's new value first appears on fields.
- Fields never leave the range 0..MOD-1. Arithmetic uses FIELD_W+1 bits internally before the wrap compare.

## Timing
- Reset values:
  - fields = 0, cursor = 0, editing = 0.
  - inc_pulse = 0, dec_pulse = 0.
  - FSM = IDLE; repeat counters = 0.
- Latency: a key high at clk edge N and low at edge N-1 gives its registered effect on all outputs right after edge N. Latency is one cycle; there is no combinational path from inputs to outputs.
- Keys are sampled every cycle. A key held high produces one edge only (unless auto-repeat is enabled).
- Reset asserted mid-edit wins over all other inputs on that cycle.
- Back-to-back edges on alternate cycles (key pattern 1,0,1) each take effect.

## Configuration
- AUTO_REPEAT_EN defined:
  - up_key and down_key held continuously in EDIT generate a synthetic edge after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles.
  - The counter clears on key release, on a set edge, or when both up and down are high.
  - Each repeat pulses inc_pulse or dec_pulse like a real edge.
- AUTO_REPEAT_EN undefined: no repeat counters are built; holding a key gives exactly one step.

## Structure
- Shared package alarm_pkg:
  - FSM state encoding: IDLE = 1'b0, EDIT = 1'b1.
  - Default moduli constants SEC_MOD = 60, MIN_MOD = 60, HOUR_MOD = 24.
- Sub-module key_edge_repeat, one instance per key:
  - Does the edge detect and the optional repeat counter.
  - Outputs a single-cycle step pulse.
  - Instances for set, left and right have repeat tied off.

## Test plan
- Reset, then set edge, then 3 up edges → editing = 1, cursor = 0, field0 = 3, three single-cycle inc_pulse = 3'b001.
- EDIT, 2 left edges, then 3 more left edges → cursor = 2 and stays 2; right ×4 → cursor = 0.
- Cursor = 2, field2 = 23, up edge → field2 = 0; then down edge → field2 = 23, dec_pulse = 3'b100.
- Same-cycle up+down, and same-cycle left+right → no change, no pulses. Same-cycle set+up in EDIT → IDLE, field unchanged.
- up_key held high through reset release → no increment. In IDLE, up edge → fields unchanged.
- AUTO_REPEAT_EN with REPEAT_DELAY = 4, REPEAT_PERIOD = 2, up held 10 cycles in EDIT → field0 increments at hold cycles 1, 5, 7, 9.
